updown_counter_n: RTL and testbench



---
 rtl/counter_pkg.sv | 13 +
 rtl/counter_prescaler.sv | 36 +++
 rtl/updown_counter_n.sv | 116 +++++++++++
 tb/tb_updown_counter_n.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared mode and FSM encodings for updown_counter_n and its helpers.
package counter_pkg;

    localparam logic [1:0] MODE_WRAP    = 2'd0;
    localparam logic [1:0] MODE_SAT     = 2'd1;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;
    localparam logic [1:0] MODE_RELOAD  = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/counter_prescaler.sv
// Step prescaler: emits a 1-cycle tick on every (psc+1)-th qualifying cycle.
module counter_prescaler #(
    parameter int unsigned PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             qual,
    input  logic [PSC_W-1:0] psc,
    output logic             tick
);

    localparam logic [PSC_W-1:0] PscOne = PSC_W'(1);

    logic [PSC_W-1:0] div_q, div_d;

    assign tick = qual && (div_q == psc);

    always_comb begin
        div_d = div_q;
        if (clr) begin
            div_d = '0;
        end else if (qual) begin
            div_d = tick ? '0 : div_q + PscOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/updown_counter_n.sv
// Parametrised up/down counter/timer with run control, terminal-count modes and sticky irq.
// Optional step prescaler enabled by defining COUNTER_PRESCALE_EN.
module updown_counter_n
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 32
`ifdef COUNTER_PRESCALE_EN
    ,
    parameter int unsigned PSC_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             s,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] pdata,
    input  logic             start,
    input  logic             stop,
    input  logic             irq_clr,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PSC_W-1:0] psc,
`endif
    output logic [WIDTH-1:0] cnt,
    output logic             rc,
    output logic             busy,
    output logic             irq
);

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [WIDTH-1:0] cnt_d;
    logic             rc_d;
    logic             irq_d;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] stepped;
    logic             qual;
    logic             step;

    assign qual = (state_q == ST_RUN) && en && !load && !stop;

`ifdef COUNTER_PRESCALE_EN
    counter_prescaler #(
        .PSC_W (PSC_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (load | stop | start),
        .qual  (qual),
        .psc   (psc),
        .tick  (step)
    );
`else
    assign step = qual;
`endif

    assign term    = s ? {WIDTH{1'b1}} : '0;
    assign stepped = s ? cnt + One : cnt - One;
    assign busy    = (state_q == ST_RUN);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt;
        reload_d = reload_q;
        rc_d     = 1'b0;

        if (load) begin
            cnt_d    = pdata;
            reload_d = pdata;
        end

        // stop still wins over start when paired with load; start needs a quiet cycle
        if (stop) begin
            state_d = ST_IDLE;
        end else if (start && !load && state_q != ST_RUN) begin
            state_d = ST_RUN;
        end

        if (step) begin
            if (cnt != term) begin
                cnt_d = stepped;
            end else begin
                rc_d = 1'b1;
                case (mode)
                    MODE_WRAP:    cnt_d = stepped;
                    MODE_SAT:     cnt_d = cnt;
                    MODE_ONESHOT: state_d = ST_DONE;
                    MODE_RELOAD:  cnt_d = reload_q;
                    default:      cnt_d = cnt;
                endcase
            end
        end

        irq_d = rc_d | (irq & !irq_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt      <= '0;
            reload_q <= '0;
            rc       <= 1'b0;
            irq      <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt      <= cnt_d;
            reload_q <= reload_d;
            rc       <= rc_d;
            irq      <= irq_d;
        end
    end

endmodule

// File: tb/tb_updown_counter_n.sv
// Directed scoreboard bench for updown_counter_n at WIDTH=8.
module tb_updown_counter_n;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         s = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic         load = 1'b0;
    logic [W-1:0] pdata = '0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         irq_clr = 1'b0;
`ifdef COUNTER_PRESCALE_EN
    logic [7:0]   psc = 8'd0;
`endif
    logic [W-1:0] cnt;
    logic         rc;
    logic         busy;
    logic         irq;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string        tag;
        logic [W-1:0] cnt;
        logic         rc;
        logic         busy;
        logic         irq;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    updown_counter_n #(
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .s       (s),
        .mode    (mode),
        .load    (load),
        .pdata   (pdata),
        .start   (start),
        .stop    (stop),
        .irq_clr (irq_clr),
`ifdef COUNTER_PRESCALE_EN
        .psc     (psc),
`endif
        .cnt     (cnt),
        .rc      (rc),
        .busy    (busy),
        .irq     (irq)
    );

    task automatic cmp(input string tag, input string field, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
        end
    endtask

    task automatic cmp_all(input exp_t e);
        cmp(e.tag, "cnt", 64'(cnt), 64'(e.cnt));
        cmp(e.tag, "rc", 64'(rc), 64'(e.rc));
        cmp(e.tag, "busy", 64'(busy), 64'(e.busy));
        cmp(e.tag, "irq", 64'(irq), 64'(e.irq));
    endtask

    // Push the expectation for the inputs just driven, clock once, then pop and compare.
    task automatic cyc(input string tag, input logic [W-1:0] c, input logic r,
                       input logic b, input logic i);
        exp_t e;
        sb.push_back('{tag: tag, cnt: c, rc: r, busy: b, irq: i});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        cmp_all(e);
    endtask

    initial begin
        exp_t e;

        #2;
        cmp_all('{tag: "reset", cnt: 8'h00, rc: 1'b0, busy: 1'b0, irq: 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        // WRAP, up
        mode = 2'd0; s = 1'b1; en = 1'b1; load = 1'b1; pdata = 8'hFE;
        cyc("wrap_load", 8'hFE, 0, 0, 0);
        load = 1'b0; start = 1'b1;
        cyc("wrap_start", 8'hFE, 0, 1, 0);
        start = 1'b0;
        cyc("wrap_ff", 8'hFF, 0, 1, 0);
        cyc("wrap_00", 8'h00, 1, 1, 1);
        cyc("wrap_01", 8'h01, 0, 1, 1);
        en = 1'b0;
        cyc("wrap_hold", 8'h01, 0, 1, 1);
        irq_clr = 1'b1;
        cyc("wrap_irqclr", 8'h01, 0, 1, 0);
        irq_clr = 1'b0; stop = 1'b1;
        cyc("wrap_stop", 8'h01, 0, 0, 0);
        stop = 1'b0;

        // SAT, down
        mode = 2'd1; s = 1'b0; en = 1'b1; load = 1'b1; pdata = 8'h01;
        cyc("sat_load", 8'h01, 0, 0, 0);
        load = 1'b0; start = 1'b1;
        cyc("sat_start", 8'h01, 0, 1, 0);
        start = 1'b0;
        cyc("sat_00", 8'h00, 0, 1, 0);
        cyc("sat_hold1", 8'h00, 1, 1, 1);
        cyc("sat_hold2", 8'h00, 1, 1, 1);
        stop = 1'b1; irq_clr = 1'b1;
        cyc("sat_stop", 8'h00, 0, 0, 0);
        stop = 1'b0; irq_clr = 1'b0;

        // ONESHOT, down
        mode = 2'd2; load = 1'b1; pdata = 8'h03;
        cyc("os_load", 8'h03, 0, 0, 0);
        load = 1'b0; start = 1'b1;
        cyc("os_start", 8'h03, 0, 1, 0);
        start = 1'b0;
        cyc("os_02", 8'h02, 0, 1, 0);
        cyc("os_01", 8'h01, 0, 1, 0);
        cyc("os_00", 8'h00, 0, 1, 0);
        cyc("os_term", 8'h00, 1, 0, 1);
        cyc("os_done", 8'h00, 0, 0, 1);
        mode = 2'd0; start = 1'b1;
        cyc("os_restart", 8'h00, 0, 1, 1);
        start = 1'b0;
        cyc("os_wrap_ff", 8'hFF, 1, 1, 1);
        stop = 1'b1; irq_clr = 1'b1;
        cyc("os_stop", 8'hFF, 0, 0, 0);
        stop = 1'b0; irq_clr = 1'b0;

        // RELOAD, down, then coincident irq set/clear
        mode = 2'd3; load = 1'b1; pdata = 8'h02;
        cyc("rl_load", 8'h02, 0, 0, 0);
        load = 1'b0; start = 1'b1;
        cyc("rl_start", 8'h02, 0, 1, 0);
        start = 1'b0;
        cyc("rl_01a", 8'h01, 0, 1, 0);
        cyc("rl_00a", 8'h00, 0, 1, 0);
        cyc("rl_02a", 8'h02, 1, 1, 1);
        irq_clr = 1'b1;
        cyc("rl_01b", 8'h01, 0, 1, 0);
        irq_clr = 1'b0;
        cyc("rl_00b", 8'h00, 0, 1, 0);
        irq_clr = 1'b1;
        cyc("rl_setwins", 8'h02, 1, 1, 1);
        irq_clr = 1'b0;

        // load with stop while running
        load = 1'b1; stop = 1'b1; pdata = 8'h55;
        cyc("load_stop", 8'h55, 0, 0, 1);
        load = 1'b0; stop = 1'b0;

        // async reset mid-count
        mode = 2'd0; s = 1'b1; start = 1'b1;
        cyc("pre_rst_start", 8'h55, 0, 1, 1);
        start = 1'b0;
        cyc("pre_rst_step", 8'h56, 0, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        cmp_all('{tag: "async_rst", cnt: 8'h00, rc: 1'b0, busy: 1'b0, irq: 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        cyc("post_rst", 8'h00, 0, 0, 0);

`ifdef COUNTER_PRESCALE_EN
        psc = 8'd2; load = 1'b1; pdata = 8'h00;
        cyc("psc_load", 8'h00, 0, 0, 0);
        load = 1'b0; start = 1'b1;
        cyc("psc_start", 8'h00, 0, 1, 0);
        start = 1'b0;
        cyc("psc_q1", 8'h00, 0, 1, 0);
        cyc("psc_q2", 8'h00, 0, 1, 0);
        cyc("psc_q3", 8'h01, 0, 1, 0);
        en = 1'b0;
        cyc("psc_pause", 8'h01, 0, 1, 0);
        en = 1'b1;
        cyc("psc_q4", 8'h01, 0, 1, 0);
        cyc("psc_q5", 8'h01, 0, 1, 0);
        cyc("psc_q6", 8'h02, 0, 1, 0);
`endif

        checks++;
        assert (sb.size() === 0)
        else begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
